// File: rtl/mdu_div_if.sv
// mdu_div_if: request/result handshake bus for mdu_div.
// in_word exists only when MDU_DIV_WORD_EN is defined.
interface mdu_div_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic [XLEN-1:0] in_src1;
    logic [XLEN-1:0] in_src2;
    logic            kill;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
`ifdef MDU_DIV_WORD_EN
    logic            in_word;
`endif
    modport master (
`ifdef MDU_DIV_WORD_EN
        output in_word,
`endif
        output in_valid, in_op, in_src1, in_src2, kill, out_ready,
        input  in_ready, out_valid, out_result
    );
    modport slave (
`ifdef MDU_DIV_WORD_EN
        input  in_word,
`endif
        input  in_valid, in_op, in_src1, in_src2, kill, out_ready,
        output in_ready, out_valid, out_result
    );
endinterface

// File: rtl/mdu_div.sv
// mdu_div: radix-2 restoring divider for div/divu/rem/remu, one quotient bit per cycle.
// Defining MDU_DIV_WORD_EN adds in_word for 32-bit operations with sign-extended results.
module mdu_div #(
    parameter int XLEN = 64
) (
    input logic      clock,
    input logic      reset_n,
    mdu_div_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;

    logic [1:0]      state;
    logic [CW-1:0]   cnt, last;
    logic [XLEN-1:0] q, r, d, a, b, amag, bmag, load, qf, rf, res;
    logic [XLEN:0]   rs, diff;
    logic            rem_op, neg_q, neg_r, word, in_w, sgn, div0, ovf, byp;

`ifdef MDU_DIV_WORD_EN
    assign in_w = bus.in_word;
`else
    assign in_w = 1'b0;
`endif

    assign sgn  = ~bus.in_op[0];
    assign a    = in_w ? {{(XLEN-32){sgn & bus.in_src1[31]}}, bus.in_src1[31:0]} : bus.in_src1;
    assign b    = in_w ? {{(XLEN-32){sgn & bus.in_src2[31]}}, bus.in_src2[31:0]} : bus.in_src2;
    assign amag = (sgn & a[XLEN-1]) ? -a : a;
    assign bmag = (sgn & b[XLEN-1]) ? -b : b;
    assign div0 = b == '0;
    // Word-mode MIN is the sign-extended 32-bit MIN, so one comparison covers both widths
    assign ovf  = sgn & (&b) & (a == (in_w ? ~XLEN'(32'h7FFF_FFFF) : {1'b1, {(XLEN-1){1'b0}}}));
    assign byp  = div0 | ovf;
    assign load = in_w ? amag << (XLEN - 32) : amag;
    assign last = word ? CW'(31) : CW'(XLEN - 1);

    assign rs   = {r, q[XLEN-1]};
    assign diff = rs - {1'b0, d};

    // Bypass results are preloaded into q/r with sign flags cleared, so one output path serves all
    assign qf  = neg_q ? -q : q;
    assign rf  = neg_r ? -r : r;
    assign res = rem_op ? rf : qf;

    assign bus.in_ready   = state == IDLE;
    assign bus.out_valid  = state == DONE;
    assign bus.out_result = word ? {{(XLEN-32){res[31]}}, res[31:0]} : res;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            q      <= '0;
            r      <= '0;
            d      <= '0;
            rem_op <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            word   <= 1'b0;
        end else if (bus.kill) begin
            state <= IDLE;
        end else if (state == IDLE) begin
            if (bus.in_valid) begin
                state  <= byp ? DONE : BUSY;
                cnt    <= '0;
                d      <= bmag;
                rem_op <= bus.in_op[1];
                word   <= in_w;
                neg_q  <= ~byp & sgn & (a[XLEN-1] ^ b[XLEN-1]);
                neg_r  <= ~byp & sgn & a[XLEN-1];
                q      <= div0 ? '1 : ovf ? a : load;
                r      <= div0 ? a : '0;
            end
        end else if (state == BUSY) begin
            q   <= {q[XLEN-2:0], ~diff[XLEN]};
            r   <= diff[XLEN] ? rs[XLEN-1:0] : diff[XLEN-1:0];
            cnt <= cnt + CW'(1);
            if (cnt == last) state <= DONE;
        end else if (bus.out_ready) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_mdu_div.sv
// tb_mdu_div: scoreboard bench for mdu_div; expected results are queued at accept and
// compared with result and latency when out_valid rises.
module tb_mdu_div;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    mdu_div_if #(.XLEN(64)) bus ();
    mdu_div #(.XLEN(64)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    logic [63:0] sb_res[$];
    int          sb_lat[$];
    int vectors = 0;
    int miscompares = 0;

    function automatic void model(input logic [1:0] op, input logic [63:0] s1, input logic [63:0] s2,
                                  input bit w, output logic [63:0] res, output int lat);
        logic [63:0] x, y, qq, rr;
        bit s;
        s = !op[0];
        x = w ? (s ? {{32{s1[31]}}, s1[31:0]} : {32'd0, s1[31:0]}) : s1;
        y = w ? (s ? {{32{s2[31]}}, s2[31:0]} : {32'd0, s2[31:0]}) : s2;
        if (y == 64'd0) begin
            qq = '1; rr = x; lat = 1;
        end else if (s && x == 64'h8000_0000_0000_0000 && y == '1) begin
            qq = x; rr = 64'd0; lat = 1;
        end else begin
            lat = w ? 33 : 65;
            if (s) begin
                qq = $signed(x) / $signed(y);
                rr = $signed(x) % $signed(y);
            end else begin
                qq = x / y;
                rr = x % y;
            end
        end
        res = op[1] ? rr : qq;
        if (w) res = {{32{res[31]}}, res[31:0]};
    endfunction

    task automatic start(input logic [1:0] op, input logic [63:0] s1, input logic [63:0] s2);
        int n = 0;
        while (!bus.in_ready && n < 200) begin @(posedge clock); #1; n++; end
        bus.in_valid = 1'b1;
        bus.in_op = op;
        bus.in_src1 = s1;
        bus.in_src2 = s2;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL accept: in_ready=%b after accept edge, required 0", bus.in_ready);
        end
    endtask

    task automatic collect();
        int lat = 1;
        logic [63:0] e;
        int el;
        while (!bus.out_valid && lat < 200) begin
            bus.in_src1 = {$urandom, $urandom};
            bus.in_src2 = {$urandom, $urandom};
            bus.in_op = 2'($urandom);
            @(posedge clock); #1;
            lat++;
        end
        e = sb_res.pop_front();
        el = sb_lat.pop_front();
        vectors++;
        if (!bus.out_valid) begin
            miscompares++;
            $display("FAIL timeout: out_valid never rose, required result %h", e);
        end else if (bus.out_result !== e || lat != el) begin
            miscompares++;
            $display("FAIL result: got %h after %0d cycles, required %h after %0d", bus.out_result, lat, e, el);
        end
        if (bus.out_ready) begin @(posedge clock); #1; end
    endtask

    task automatic run(input logic [1:0] op, input logic [63:0] s1, input logic [63:0] s2,
                       input bit w, input logic [63:0] e, input int el);
`ifdef MDU_DIV_WORD_EN
        bus.in_word = w;
`endif
        start(op, s1, s2);
        sb_res.push_back(e);
        sb_lat.push_back(el);
        collect();
`ifdef MDU_DIV_WORD_EN
        bus.in_word = 1'b0;
`endif
    endtask

    task automatic run_model(input logic [1:0] op, input logic [63:0] s1, input logic [63:0] s2, input bit w);
        logic [63:0] e;
        int el;
        model(op, s1, s2, w, e, el);
        run(op, s1, s2, w, e, el);
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_result !== 64'd0) begin
            miscompares++;
            $display("FAIL reset: in_ready=%b out_valid=%b out_result=%h, required 1 0 0",
                     bus.in_ready, bus.out_valid, bus.out_result);
        end
        reset_n = 1'b1;
        run(2'b01, 64'd7, 64'd2, 1'b0, 64'd3, 65);
    endtask

    task automatic test_div();
        run(2'b00, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 64'hFFFF_FFFF_FFFF_FFF2, 65);
        run(2'b10, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 64'd2, 65);
        run(2'b00, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFF2, 65);
        run(2'b10, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        run(2'b00, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 64'd14, 65);
        run(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 65);
        run(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 1'b0, 64'd15, 65);
    endtask

    task automatic test_special();
        run(2'b01, 64'd5, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run(2'b11, 64'd5, 64'd0, 1'b0, 64'd5, 1);
        run(2'b10, 64'hFFFF_FFFF_FFFF_FFF7, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF7, 1);
        run(2'b00, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1);
        run(2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 1);
        run(2'b01, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 65);
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        run(2'b01, 64'd100, 64'd3, 1'b0, 64'd33, 65);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_src1 = {$urandom, $urandom};
            bus.in_src2 = {$urandom, $urandom};
            @(posedge clock); #1;
            vectors++;
            if (bus.out_result !== 64'd33 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL hold%0d: result=%h out_valid=%b in_ready=%b, required 33 1 0",
                         i, bus.out_result, bus.out_valid, bus.in_ready);
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clock); #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL handoff: out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_kill();
        bit seen = 1'b0;
        start(2'b01, 64'd1000, 64'd9);
        repeat (30) begin @(posedge clock); #1; end
        bus.kill = 1'b1;
        @(posedge clock); #1;
        bus.kill = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL kill: out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
        end
        repeat (80) begin @(posedge clock); #1; seen |= bus.out_valid; end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL kill_silent: out_valid rose=%b, required 0", seen);
        end
        bus.kill = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_op = 2'b01;
        bus.in_src2 = 64'd3;
        @(posedge clock); #1;
        bus.kill = 1'b0;
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL kill_over_valid: in_ready=%b, required 1", bus.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        start(2'b01, 64'd12345, 64'd11);
        repeat (40) begin @(posedge clock); #1; end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_result !== 64'd0) begin
            miscompares++;
            $display("FAIL async_reset: in_ready=%b out_valid=%b out_result=%h, required 1 0 0",
                     bus.in_ready, bus.out_valid, bus.out_result);
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (70) begin @(posedge clock); #1; seen |= bus.out_valid; end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL reset_silent: out_valid rose=%b, required 0", seen);
        end
        run(2'b01, 64'd7, 64'd2, 1'b0, 64'd3, 65);
    endtask

    task automatic test_back_to_back();
        logic [63:0] s1, s2;
        for (int i = 0; i < 20; i++) begin
            s1 = {$urandom, $urandom};
            s2 = {$urandom, $urandom} >> $urandom_range(0, 62);
            if (i % 7 == 3) s2 = 64'd0;
            if (i % 5 == 1) s2 = 64'hFFFF_FFFF_FFFF_FFFF;
            run_model(2'($urandom), s1, s2, 1'b0);
        end
    endtask

`ifdef MDU_DIV_WORD_EN
    task automatic test_word();
        run(2'b00, 64'h1_FFFF_FFF9, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 33);
        run(2'b11, 64'hABCD_0000_0000_0009, 64'd0, 1'b1, 64'd9, 1);
        run(2'b00, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_8000_0000, 1);
        for (int i = 0; i < 8; i++)
            run_model(2'($urandom), {$urandom, $urandom}, {$urandom, 32'($urandom_range(1, 70000))}, 1'b1);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_op = 2'b00;
        bus.in_src1 = '0;
        bus.in_src2 = '0;
        bus.kill = 1'b0;
        bus.out_ready = 1'b1;
`ifdef MDU_DIV_WORD_EN
        bus.in_word = 1'b0;
`endif
        test_reset();
        test_div();
        test_special();
        test_backpressure();
        test_kill();
        test_reset_mid();
        test_back_to_back();
`ifdef MDU_DIV_WORD_EN
        test_word();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
